// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with majority-vote bit sampling and a first-word fall-through byte FIFO.
// Optional even-parity support is enabled by defining UART_RX_PARITY_EN.
module uart_rx_fifo #(
  parameter int CLK_HZ     = 16000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rx_i,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic [2:0] o_dbg_state
);

  localparam int CPB = CLK_HZ / BAUD;
  localparam int MID = CPB / 2;
  localparam int CW  = $clog2(CPB);
  localparam int AW  = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  state_t          r_state;
  logic [1:0]      r_sync;
  logic [2:0]      r_taps;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_bitn;
  logic [7:0]      r_shift;
  logic            r_frame_err;
  logic            r_overrun;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW:0]     r_wptr;
  logic [AW:0]     r_rptr;
`ifdef UART_RX_PARITY_EN
  logic            r_par_bad;
  logic            r_parity_err;
`endif

  logic w_line, w_major, w_mid, w_bit_end;
  logic w_push, w_pop, w_wr, w_empty, w_full;

  assign w_line    = r_sync[1];
  assign w_major   = (r_taps[0] & r_taps[1]) | (r_taps[0] & r_taps[2]) | (r_taps[1] & r_taps[2]);
  assign w_mid     = (r_cnt == CW'(MID));
  assign w_bit_end = (r_cnt == CW'(CPB - 1));

  // A byte is pushed on the very edge its stop bit is sampled high.
`ifdef UART_RX_PARITY_EN
  assign w_push = (r_state == S_STOP) && w_bit_end && w_major && !r_par_bad;
`else
  assign w_push = (r_state == S_STOP) && w_bit_end && w_major;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync <= 2'b11;
      r_taps <= 3'b111;
    end else begin
      r_sync <= {r_sync[0], rx_i};
      r_taps <= {r_taps[1:0], r_sync[1]};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bitn      <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bad    <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (!w_line) begin
            r_state <= S_START;
            r_cnt   <= '0;
          end
        end
        S_START: begin
          if (w_mid) begin
            r_cnt  <= '0;
            r_bitn <= '0;
            r_state <= w_major ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_shift <= {w_major, r_shift[7:1]};
            r_bitn  <= r_bitn + 3'd1;
            if (r_bitn == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (w_bit_end) begin
            r_cnt        <= '0;
            r_par_bad    <= ^{r_shift, w_major};
            r_parity_err <= ^{r_shift, w_major};
            r_state      <= S_STOP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
`endif
        S_STOP: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (w_major) begin
              r_state <= S_IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= S_BREAK;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_BREAK: begin
          if (w_line) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Full when the pointers alias to the same slot but differ in wrap bit.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop   = !w_empty && rx_ready;
  assign w_wr    = w_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= r_shift;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_push && w_full && !w_pop;
      if (w_wr)  r_wptr <= r_wptr + (AW+1)'(1);
      if (w_pop) r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  assign rx_valid    = !w_empty;
  assign rx_data     = w_empty ? 8'h00 : r_mem[r_rptr[AW-1:0]];
  assign frame_err   = r_frame_err;
  assign overrun     = r_overrun;
  assign busy        = (r_state != S_IDLE);
  assign o_dbg_state = r_state;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = r_parity_err;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: drives serial frames and compares the popped bytes and
// error pulses against a queue-based model of the receive FIFO.
module tb_uart_rx_fifo;

  localparam int CPB   = 16000000 / 115200;
  localparam int MID   = CPB / 2;
  localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
  localparam int STOP_IDX = 10;
`else
  localparam int STOP_IDX = 9;
`endif

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       rx_i = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun, busy;
  logic [2:0] dbg_state;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int checks = 0;
  int failures = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int pe_cnt = 0;
  logic [7:0] exp_q[$];

  uart_rx_fifo dut (
    .clk(clk), .resetn(resetn), .rx_i(rx_i), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun), .busy(busy),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err === 1'b1) fe_cnt++;
    if (overrun === 1'b1) ov_cnt++;
`ifdef UART_RX_PARITY_EN
    if (parity_err === 1'b1) pe_cnt++;
`endif
  end

  // drivers: every task starts and ends on a falling clock edge
  task automatic send_bit(input logic b);
    rx_i = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    rx_i = 1'b1;
    repeat (n * CPB) @(negedge clk);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_par(input logic [7:0] d, input logic par, input logic stop_b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stop_b);
  endtask
`endif

  task automatic send_frame(input logic [7:0] d, input logic stop_b);
`ifdef UART_RX_PARITY_EN
    send_frame_par(d, ^d, stop_b);
`else
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop_b);
`endif
  endtask

  task automatic pop_byte(output logic v, output logic [7:0] d);
    v = rx_valid;
    d = rx_data;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic test_reset;
    rx_i = 1'b1; rx_ready = 1'b0; resetn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rx_valid, rx_data, frame_err, overrun, busy} !== 12'h000) begin
      failures++;
      $display("FAIL reset_values: got v=%b d=%h fe=%b ov=%b busy=%b, want all 0",
               rx_valid, rx_data, frame_err, overrun, busy);
    end
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (rx_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL after_reset_idle: got v=%b busy=%b want 0 0", rx_valid, busy);
    end
  endtask

  task automatic test_basic;
    logic v; logic [7:0] d;
    send_frame(8'h55, 1'b1);
    idle_bits(1);
    send_frame(8'hA3, 1'b1);
    idle_bits(1);
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h55) begin
      failures++;
      $display("FAIL basic_head: got v=%b d=%h want 1 55", rx_valid, rx_data);
    end
    pop_byte(v, d);
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'hA3) begin
      failures++;
      $display("FAIL basic_second: got v=%b d=%h want 1 a3", rx_valid, rx_data);
    end
    pop_byte(v, d);
    checks++;
    if (rx_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_empty: got v=%b want 0", rx_valid);
    end
  endtask

  task automatic test_glitch;
    int fe0 = fe_cnt;
    rx_i = 1'b0;
    repeat (15) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL glitch_busy_rise: got %b want 1", busy);
    end
    repeat (5) @(negedge clk);
    idle_bits(2);
    checks++;
    if (busy !== 1'b0 || rx_valid !== 1'b0 || fe_cnt != fe0) begin
      failures++;
      $display("FAIL glitch_ignored: got busy=%b v=%b fe=%0d want 0 0 0", busy, rx_valid, fe_cnt - fe0);
    end
  endtask

  task automatic test_frame_err;
    logic v; logic [7:0] d;
    int fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0);
    rx_i = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    idle_bits(2);
    send_frame(8'h7E, 1'b1);
    idle_bits(1);
    checks++;
    if (fe_cnt - fe0 != 1) begin
      failures++;
      $display("FAIL frame_err_count: got %0d want 1", fe_cnt - fe0);
    end
    pop_byte(v, d);
    checks++;
    if (v !== 1'b1 || d !== 8'h7E) begin
      failures++;
      $display("FAIL frame_err_next_byte: got v=%b d=%h want 1 7e", v, d);
    end
    checks++;
    if (rx_valid !== 1'b0) begin
      failures++;
      $display("FAIL frame_err_only_entry: got v=%b want 0", rx_valid);
    end
  endtask

  task automatic test_overrun;
    logic v; logic [7:0] d;
    int ov0 = ov_cnt;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
    checks++;
    if (ov_cnt - ov0 != 1) begin
      failures++;
      $display("FAIL overrun_count: got %0d want 1", ov_cnt - ov0);
    end
    for (int i = 1; i <= 4; i++) begin
      pop_byte(v, d);
      checks++;
      if (v !== 1'b1 || d !== 8'(i)) begin
        failures++;
        $display("FAIL overrun_drain: got v=%b d=%h want 1 %h", v, d, 8'(i));
      end
    end
    checks++;
    if (rx_valid !== 1'b0) begin
      failures++;
      $display("FAIL overrun_empty: got v=%b want 0", rx_valid);
    end
  endtask

  // With the line falling on a falling clock edge, the stop bit is sampled (and pushed) on the
  // rising edge 4 + MID + STOP_IDX*CPB later: two sync flops, one IDLE cycle, then counters.
  task automatic test_full_pop;
    logic v; logic [7:0] d;
    int ov0;
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
    ov0 = ov_cnt;
    fork
      send_frame(8'h05, 1'b1);
      begin
        repeat (3 + MID + STOP_IDX * CPB) @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
      end
    join
    checks++;
    if (ov_cnt != ov0) begin
      failures++;
      $display("FAIL full_pop_no_overrun: got %0d pulses want 0", ov_cnt - ov0);
    end
    for (int i = 2; i <= 5; i++) begin
      pop_byte(v, d);
      checks++;
      if (v !== 1'b1 || d !== 8'(i)) begin
        failures++;
        $display("FAIL full_pop_drain: got v=%b d=%h want 1 %h", v, d, 8'(i));
      end
    end
    checks++;
    if (rx_valid !== 1'b0) begin
      failures++;
      $display("FAIL full_pop_empty: got v=%b want 0", rx_valid);
    end
  endtask

  task automatic test_random;
    logic v; logic [7:0] d, b;
    int ov0 = ov_cnt;
    int exp_ov = 0;
    int npop;
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1'b1);
      if ($urandom_range(0, 1) == 1) idle_bits(1);
      if (exp_q.size() < DEPTH) exp_q.push_back(b);
      else exp_ov++;
      npop = $urandom_range(0, 2);
      for (int k = 0; k < npop; k++) begin
        pop_byte(v, d);
        checks++;
        if (exp_q.size() > 0) begin
          if (v !== 1'b1 || d !== exp_q[0]) begin
            failures++;
            $display("FAIL random_pop: got v=%b d=%h want 1 %h", v, d, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end else if (v !== 1'b0) begin
          failures++;
          $display("FAIL random_pop_empty: got v=%b want 0", v);
        end
      end
    end
    while (exp_q.size() > 0) begin
      pop_byte(v, d);
      checks++;
      if (v !== 1'b1 || d !== exp_q[0]) begin
        failures++;
        $display("FAIL random_drain: got v=%b d=%h want 1 %h", v, d, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    checks++;
    if (rx_valid !== 1'b0 || ov_cnt - ov0 != exp_ov) begin
      failures++;
      $display("FAIL random_end: got v=%b overruns=%0d want 0 %0d", rx_valid, ov_cnt - ov0, exp_ov);
    end
  endtask

  task automatic test_reset_midframe;
    logic v; logic [7:0] d;
    send_frame(8'h5A, 1'b1);
    fork
      send_frame(8'h81, 1'b1);
      begin
        repeat (2 * CPB + CPB / 2) @(negedge clk);
        resetn = 1'b0;
        repeat (5) begin
          @(negedge clk);
          checks++;
          if ({rx_valid, rx_data, frame_err, overrun, busy} !== 12'h000) begin
            failures++;
            $display("FAIL midframe_reset_values: got v=%b d=%h fe=%b ov=%b busy=%b want all 0",
                     rx_valid, rx_data, frame_err, overrun, busy);
          end
        end
        repeat (4 * CPB + 10 - (2 * CPB + CPB / 2) - 5) @(negedge clk);
        resetn = 1'b1;
      end
    join
    idle_bits(6);
    for (int k = 0; k < DEPTH; k++) begin
      if (rx_valid === 1'b1) begin
        pop_byte(v, d);
        checks++;
        if (d === 8'h81 || d === 8'h5A) begin
          failures++;
          $display("FAIL midframe_no_stale_byte: got %h, 81 and 5a must not appear", d);
        end
      end
    end
    send_frame(8'h42, 1'b1);
    idle_bits(1);
    pop_byte(v, d);
    checks++;
    if (v !== 1'b1 || d !== 8'h42) begin
      failures++;
      $display("FAIL midframe_recover: got v=%b d=%h want 1 42", v, d);
    end
    checks++;
    if (rx_valid !== 1'b0) begin
      failures++;
      $display("FAIL midframe_recover_empty: got v=%b want 0", rx_valid);
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    logic v; logic [7:0] d;
    int pe0 = pe_cnt;
    send_frame_par(8'h07, 1'b0, 1'b1);
    idle_bits(1);
    checks++;
    if (pe_cnt - pe0 != 1 || rx_valid !== 1'b0) begin
      failures++;
      $display("FAIL parity_bad: got pulses=%0d v=%b want 1 0", pe_cnt - pe0, rx_valid);
    end
    send_frame_par(8'h07, 1'b1, 1'b1);
    idle_bits(1);
    pop_byte(v, d);
    checks++;
    if (v !== 1'b1 || d !== 8'h07 || pe_cnt - pe0 != 1) begin
      failures++;
      $display("FAIL parity_good: got v=%b d=%h pulses=%0d want 1 07 1", v, d, pe_cnt - pe0);
    end
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_full_pop();
    test_random();
    test_reset_midframe();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
